// File: rtl/note_renderer_pkg.sv
`default_nettype none
// ============================================================================
// note_renderer_pkg: geometry, colours, command encoding and priority select
// Rev 1.0
// ============================================================================
package note_renderer_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int LANE_W   = 40;
    localparam int NOTE_H   = 15;
    localparam int ROWS     = 8;
    localparam int LANES    = 4;

    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COL_W    = 3;
    localparam int XOFF_W   = $clog2(LANE_W);
    localparam int YIN_W    = $clog2(NOTE_H);
    localparam int SLOT_W   = $clog2(ROWS);
    localparam int LANE_IW  = 2;
    localparam int NIDX_W   = $clog2(LANES * ROWS);

    localparam logic [COL_W-1:0] C_BG    = 3'b000;
    localparam logic [COL_W-1:0] C_DIV   = 3'b111;
    localparam logic [COL_W-1:0] C_LANE0 = 3'b010;
    localparam logic [COL_W-1:0] C_LANE1 = 3'b100;
    localparam logic [COL_W-1:0] C_LANE2 = 3'b110;
    localparam logic [COL_W-1:0] C_LANE3 = 3'b001;

    localparam int CMD_W = 6;
    typedef logic [CMD_W-1:0] cmd_t;

    localparam cmd_t CMD_NONE   = 6'b000000;
    localparam cmd_t CMD_ERASE  = 6'b000001;
    localparam cmd_t CMD_BOARD  = 6'b000010;
    localparam cmd_t CMD_NOTES1 = 6'b000100;
    localparam cmd_t CMD_NOTES2 = 6'b001000;
    localparam cmd_t CMD_NOTES3 = 6'b010000;
    localparam cmd_t CMD_NOTES4 = 6'b100000;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Bit 0 is the highest priority, so isolating the lowest set bit picks the winner.
    function automatic cmd_t prio_select(input cmd_t raw);
        return raw & (~raw + cmd_t'(1));
    endfunction

    function automatic logic [COL_W-1:0] lane_colour(input logic [LANE_IW-1:0] lane);
        case (lane)
            2'd0:    return C_LANE0;
            2'd1:    return C_LANE1;
            2'd2:    return C_LANE2;
            default: return C_LANE3;
        endcase
    endfunction

    function automatic logic [X_W-1:0] lane_base(input logic [LANE_IW-1:0] lane);
        case (lane)
            2'd0:    return X_W'(0);
            2'd1:    return X_W'(LANE_W);
            2'd2:    return X_W'(2 * LANE_W);
            default: return X_W'(3 * LANE_W);
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/note_renderer_region_scanner.sv
`default_nettype none
// ============================================================================
// region_scanner: nested x_off/y_in/slot/lane counters with running base offsets
// Rev 1.0
// ============================================================================
module region_scanner
    import note_renderer_pkg::*;
(
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic               step_i,
    input  logic [XOFF_W-1:0]  x_min_i,
    input  logic [XOFF_W-1:0]  x_max_i,
    input  logic [YIN_W-1:0]   y_min_i,
    input  logic [YIN_W-1:0]   y_max_i,
    input  logic [LANE_IW-1:0] lane_min_i,
    input  logic [LANE_IW-1:0] lane_max_i,
    output logic [X_W-1:0]     x_o,
    output logic [Y_W-1:0]     y_o,
    output logic [XOFF_W-1:0]  x_off_o,
    output logic [YIN_W-1:0]   y_in_o,
    output logic [SLOT_W-1:0]  slot_o,
    output logic [LANE_IW-1:0] lane_o,
    output logic               last_o
);

    logic [XOFF_W-1:0]  x_off_q, x_off_d;
    logic [YIN_W-1:0]   y_in_q, y_in_d;
    logic [SLOT_W-1:0]  slot_q, slot_d;
    logic [LANE_IW-1:0] lane_q, lane_d;
    logic [X_W-1:0]     lane_base_q, lane_base_d;
    logic [Y_W-1:0]     slot_base_q, slot_base_d;

    logic w_x_wrap, w_y_wrap, w_s_wrap, w_l_wrap;

    assign w_x_wrap = (x_off_q == x_max_i);
    assign w_y_wrap = (y_in_q == y_max_i);
    assign w_s_wrap = (slot_q == SLOT_W'(ROWS - 1));
    assign w_l_wrap = (lane_q == lane_max_i);

    assign last_o  = w_x_wrap & w_y_wrap & w_s_wrap & w_l_wrap;
    assign x_o     = lane_base_q + X_W'(x_off_q);
    assign y_o     = slot_base_q + Y_W'(y_in_q);
    assign x_off_o = x_off_q;
    assign y_in_o  = y_in_q;
    assign slot_o  = slot_q;
    assign lane_o  = lane_q;

    always_comb begin
        x_off_d     = x_off_q;
        y_in_d      = y_in_q;
        slot_d      = slot_q;
        lane_d      = lane_q;
        lane_base_d = lane_base_q;
        slot_base_d = slot_base_q;
        if (start_i) begin
            x_off_d     = x_min_i;
            y_in_d      = y_min_i;
            slot_d      = '0;
            lane_d      = lane_min_i;
            lane_base_d = lane_base(lane_min_i);
            slot_base_d = '0;
        end else if (step_i) begin
            if (!w_x_wrap) begin
                x_off_d = x_off_q + XOFF_W'(1);
            end else begin
                x_off_d = x_min_i;
                if (!w_y_wrap) begin
                    y_in_d = y_in_q + YIN_W'(1);
                end else begin
                    y_in_d = y_min_i;
                    if (!w_s_wrap) begin
                        slot_d      = slot_q + SLOT_W'(1);
                        slot_base_d = slot_base_q + Y_W'(NOTE_H);
                    end else begin
                        slot_d      = '0;
                        slot_base_d = '0;
                        lane_d      = lane_q + LANE_IW'(1);
                        lane_base_d = lane_base_q + X_W'(LANE_W);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            x_off_q     <= '0;
            y_in_q      <= '0;
            slot_q      <= '0;
            lane_q      <= '0;
            lane_base_q <= '0;
            slot_base_q <= '0;
        end else begin
            x_off_q     <= x_off_d;
            y_in_q      <= y_in_d;
            slot_q      <= slot_d;
            lane_q      <= lane_d;
            lane_base_q <= lane_base_d;
            slot_base_q <= slot_base_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/note_renderer.sv
`default_nettype none
// ============================================================================
// note_renderer: command-driven pixel scan to the VGA adapter; NOTE_RENDERER_GRID_EN adds slot separators
// Rev 1.0
// ============================================================================
module note_renderer
    import note_renderer_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  erase_notes_i,
    input  logic                  draw_board_i,
    input  logic                  draw_notes1_i,
    input  logic                  draw_notes2_i,
    input  logic                  draw_notes3_i,
    input  logic                  draw_notes4_i,
    input  logic [LANES*ROWS-1:0] lane_notes_i,
    output logic                  updating_o,
    output logic [X_W-1:0]        x_o,
    output logic [Y_W-1:0]        y_o,
    output logic [COL_W-1:0]      colour_o,
    output logic                  plot_o
);

`ifdef NOTE_RENDERER_GRID_EN
    localparam logic C_GRID_EN = 1'b1;
`else
    localparam logic C_GRID_EN = 1'b0;
`endif

    state_t                state_q, state_d;
    cmd_t                  cmd_q, cmd_d;
    cmd_t                  done_q, done_d;
    logic [LANES*ROWS-1:0] notes_q, notes_d;
    logic [X_W-1:0]        x_q, x_d;
    logic [Y_W-1:0]        y_q, y_d;
    logic [COL_W-1:0]      colour_q, colour_d;
    logic                  plot_q, plot_d;

    cmd_t                  w_raw, w_win, w_sel;
    logic                  w_busy, w_start, w_step, w_last;
    logic [XOFF_W-1:0]     w_xmin, w_xmax, w_xoff;
    logic [YIN_W-1:0]      w_ymin, w_ymax, w_yin;
    logic [LANE_IW-1:0]    w_lmin, w_lmax, w_lane;
    logic [SLOT_W-1:0]     w_slot;
    logic [X_W-1:0]        w_sx;
    logic [Y_W-1:0]        w_sy;
    logic [NIDX_W-1:0]     w_bit_idx;
    logic [COL_W-1:0]      w_colour;

    assign w_raw = {draw_notes4_i, draw_notes3_i, draw_notes2_i,
                    draw_notes1_i, draw_board_i, erase_notes_i};
    assign w_win = prio_select(w_raw);
    // Bounds must be valid on the start edge, before the command is registered.
    assign w_sel = (state_q == S_IDLE) ? w_win : cmd_q;

    always_comb begin
        w_xmin = XOFF_W'(2);
        w_xmax = XOFF_W'(LANE_W - 3);
        w_ymin = YIN_W'(1);
        w_ymax = YIN_W'(NOTE_H - 2);
        w_lmin = 2'd0;
        w_lmax = 2'd3;
        case (w_sel)
            CMD_BOARD: begin
                w_xmin = '0;
                w_xmax = XOFF_W'(LANE_W - 1);
                w_ymin = '0;
                w_ymax = YIN_W'(NOTE_H - 1);
            end
            CMD_NOTES1: begin w_lmin = 2'd0; w_lmax = 2'd0; end
            CMD_NOTES2: begin w_lmin = 2'd1; w_lmax = 2'd1; end
            CMD_NOTES3: begin w_lmin = 2'd2; w_lmax = 2'd2; end
            CMD_NOTES4: begin w_lmin = 2'd3; w_lmax = 2'd3; end
            default: ;
        endcase
    end

    region_scanner u_scanner (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .start_i    (w_start),
        .step_i     (w_step),
        .x_min_i    (w_xmin),
        .x_max_i    (w_xmax),
        .y_min_i    (w_ymin),
        .y_max_i    (w_ymax),
        .lane_min_i (w_lmin),
        .lane_max_i (w_lmax),
        .x_o        (w_sx),
        .y_o        (w_sy),
        .x_off_o    (w_xoff),
        .y_in_o     (w_yin),
        .slot_o     (w_slot),
        .lane_o     (w_lane),
        .last_o     (w_last)
    );

    assign w_bit_idx = NIDX_W'(int'(w_lane) * ROWS + int'(w_slot));

    always_comb begin
        w_colour = C_BG;
        case (cmd_q)
            CMD_BOARD: begin
                if ((w_xoff == '0) || (C_GRID_EN && (w_yin == '0))) begin
                    w_colour = C_DIV;
                end
            end
            CMD_ERASE: w_colour = C_BG;
            default: begin
                if (notes_q[w_bit_idx]) begin
                    w_colour = lane_colour(w_lane);
                end
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        done_d   = done_q;
        notes_d  = notes_q;
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        plot_d   = 1'b0;
        w_busy   = 1'b0;
        w_start  = 1'b0;
        w_step   = 1'b0;
        // Dropping all strobes re-arms the last command so the board redraws every loop.
        if (w_raw == CMD_NONE) begin
            done_d = CMD_NONE;
        end
        case (state_q)
            S_IDLE: begin
                w_busy = (w_win != CMD_NONE) && (w_win != done_q);
                if (w_busy) begin
                    w_start = 1'b1;
                    cmd_d   = w_win;
                    notes_d = lane_notes_i;
                    state_d = S_RUN;
                end
            end
            default: begin
                w_busy   = 1'b1;
                w_step   = 1'b1;
                plot_d   = 1'b1;
                x_d      = w_sx;
                y_d      = w_sy;
                colour_d = w_colour;
                if (w_last) begin
                    done_d  = cmd_q;
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            cmd_q    <= CMD_NONE;
            done_q   <= CMD_NONE;
            notes_q  <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            done_q   <= done_d;
            notes_q  <= notes_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
        end
    end

    assign updating_o = w_busy & ~reset_i;
    assign x_o        = x_q;
    assign y_o        = y_q;
    assign colour_o   = colour_q;
    assign plot_o     = plot_q;

endmodule
`default_nettype wire

// File: tb/tb_note_renderer.sv
`default_nettype none
// ============================================================================
// tb_note_renderer: randomized command sequences against a pixel-list reference model
// Rev 1.0
// ============================================================================
module tb_note_renderer;

    localparam int LW = 40;
    localparam int NH = 15;
    localparam int NR = 8;
`ifdef NOTE_RENDERER_GRID_EN
    localparam bit GRID = 1'b1;
`else
    localparam bit GRID = 1'b0;
`endif

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic [5:0]  cmd   = '0;
    logic [31:0] notes = '0;
    logic        updating;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot;

    int n_total = 0;
    int n_bad   = 0;
    int lane_col [4] = '{2, 4, 6, 1};

    logic [17:0] exp_q [$];
    logic [17:0] got_q [$];

    always #5 clk = ~clk;

    note_renderer dut (
        .clk_i         (clk),
        .reset_i       (rst),
        .erase_notes_i (cmd[0]),
        .draw_board_i  (cmd[1]),
        .draw_notes1_i (cmd[2]),
        .draw_notes2_i (cmd[3]),
        .draw_notes3_i (cmd[4]),
        .draw_notes4_i (cmd[5]),
        .lane_notes_i  (notes),
        .updating_o    (updating),
        .x_o           (x),
        .y_o           (y),
        .colour_o      (colour),
        .plot_o        (plot)
    );

    always @(posedge clk) begin
        #3;
        if (!rst && plot) got_q.push_back({x, y, colour});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] pix(input int px, input int py, input int pc);
        return {8'(px), 7'(py), 3'(pc)};
    endfunction

    // k: 0 erase, 1 board, 2..5 notes1..4
    function automatic void build_expected(input int k, input logic [31:0] nb);
        exp_q.delete();
        for (int ln = 0; ln < 4; ln++) begin
            if (k >= 2 && ln != k - 2) continue;
            for (int s = 0; s < NR; s++)
                for (int yi = 0; yi < NH; yi++)
                    for (int xo = 0; xo < LW; xo++) begin
                        bit inner;
                        int c;
                        inner = (xo >= 2) && (xo <= LW - 3) && (yi >= 1) && (yi <= NH - 2);
                        if (k != 1 && !inner) continue;
                        if (k == 1)      c = (xo == 0 || (GRID && yi == 0)) ? 7 : 0;
                        else if (k == 0) c = 0;
                        else             c = nb[ln * NR + s] ? lane_col[ln] : 0;
                        exp_q.push_back(pix(ln * LW + xo, s * NH + yi, c));
                    end
        end
    endfunction

    function automatic int find_colour(input int px, input int py);
        foreach (got_q[i]) begin
            logic [17:0] p;
            p = got_q[i];
            if (p[17:10] == 8'(px) && p[9:3] == 7'(py)) return int'(p[2:0]);
        end
        return -1;
    endfunction

    function automatic logic [14:0] xy_of(input int idx);
        logic [17:0] p;
        p = (idx < got_q.size()) ? got_q[idx] : 18'h3FFFF;
        return p[17:3];
    endfunction

    task automatic start_cmd(input int k, input logic [5:0] extra, input logic [31:0] nb);
        logic [5:0] hi;
        hi = ~((6'd1 << (k + 1)) - 6'd1);
        build_expected(k, nb);
        @(posedge clk);
        #1;
        got_q.delete();
        notes = nb;
        cmd   = (6'd1 << k) | (extra & hi);
    endtask

    task automatic finish_cmd(input string tag);
        int up;
        int bad;
        int n;
        up = 0;
        bad = 0;
        @(negedge clk);
        while (updating === 1'b1 && up < 40000) begin
            up++;
            @(negedge clk);
        end
        check({tag, ":busy_cycles"}, up, exp_q.size() + 1);
        check({tag, ":plot_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (got_q[i] !== exp_q[i]) begin
                if (bad == 0) $display("%s first pixel diff at %0d: got=%h exp=%h", tag, i, got_q[i], exp_q[i]);
                bad++;
            end
        end
        check({tag, ":pixel_errors"}, bad, 0);
    endtask

    task automatic drop_cmd();
        @(posedge clk);
        #1;
        cmd = '0;
        @(posedge clk);
    endtask

    initial begin
        int viol;
        logic [31:0] nb;

        repeat (3) @(posedge clk);
        #2;
        check("reset:plot", plot, 0);
        check("reset:x", x, 0);
        check("reset:y", y, 0);
        check("reset:colour", colour, 0);
        check("reset:updating", updating, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle:updating", updating, 0);

        // board scan, then held to 30000 cycles in total
        start_cmd(1, 6'd0, $urandom());
        finish_cmd("board");
        check("board:px0_0", find_colour(0, 0), 7);
        check("board:px1_0", find_colour(1, 0), 0);
        check("board:last", got_q[got_q.size() - 1], pix(159, 119, 0));
        check("board:px5_15", find_colour(5, 15), GRID ? 7 : 0);
        viol = 0;
        repeat (30000 - 19201) begin
            @(negedge clk);
            if (updating !== 1'b0 || plot !== 1'b0) viol++;
        end
        check("board_hold:retrigger", viol, 0);
        drop_cmd();

        // notes1 then notes2 back to back
        nb = ($urandom() & ~32'hFF) | 32'h4;
        start_cmd(2, 6'd0, nb);
        finish_cmd("notes1");
        check("notes1:first_xy", xy_of(0), {8'd2, 7'd1});
        check("notes1:first_colour", got_q[0], pix(2, 1, 0));
        check("notes1:px2_31", find_colour(2, 31), 2);
        start_cmd(3, 6'($urandom()), $urandom());
        finish_cmd("notes2");
        check("notes2:first_xy", xy_of(0), {8'd42, 7'd1});
        drop_cmd();

        // reset in the middle of notes3
        start_cmd(4, 6'd0, $urandom());
        repeat (500) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_mid:plot", plot, 0);
        check("rst_mid:updating", updating, 0);
        repeat (2) @(posedge clk);
        #1;
        got_q.delete();
        rst = 1'b0;
        finish_cmd("notes3_restart");
        check("notes3_restart:first_xy", xy_of(0), {8'd82, 7'd1});
        drop_cmd();

        // erase with random lower-priority strobes also raised
        start_cmd(0, 6'($urandom()), $urandom());
        finish_cmd("erase");
        drop_cmd();

        for (int i = 0; i < 3; i++) begin
            start_cmd(2 + int'($urandom_range(3, 0)), 6'($urandom()), $urandom());
            finish_cmd("rand_notes");
            drop_cmd();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
